// File: rtl/alu_op_decoder.sv
// alu_op_decoder: registered decode stage turning a MIPS instruction word
// into ALU control fields (ALUFun, Sign, operand/immediate selects).
// Valid/ready on both sides with a one-entry skid buffer so in_ready is a
// flop and never depends combinationally on out_ready.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN -- flags unrecognised
// encodings on `illegal` and stalls intake in a TRAP state until exc_ack.
module alu_op_decoder #(
    parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr_in,
    input  logic [31:0] tag_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  ALUFun,
    output logic        Sign,
    output logic        alu_src1_shamt,
    output logic        alu_src2_imm,
    output logic        ext_signed,
    output logic        lui,
    output logic [31:0] instr_out,
    output logic [31:0] tag_out,
    output logic        illegal,
    input  logic        exc_ack
);

    typedef struct packed {
        logic [5:0] alu_fun;
        logic       sign;
        logic       src1_shamt;
        logic       src2_imm;
        logic       ext_signed;
        logic       lui;
        logic       illegal;
    } dec_t;

    // Field decode; anything unlisted yields all-zero controls with illegal set.
    function automatic dec_t decode(input logic [5:0] op, input logic [4:0] rt,
                                    input logic [5:0] fn);
        dec_t d;
        d = '0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: begin d.alu_fun = 6'b000000; d.sign = 1'b1; end
                    6'h21: d.alu_fun = 6'b000000;
                    6'h22: begin d.alu_fun = 6'b000001; d.sign = 1'b1; end
                    6'h23: d.alu_fun = 6'b000001;
                    6'h24: d.alu_fun = 6'b011000;
                    6'h25: d.alu_fun = 6'b011110;
                    6'h26: d.alu_fun = 6'b010110;
                    6'h27: d.alu_fun = 6'b010001;
                    6'h2a: begin d.alu_fun = 6'b110101; d.sign = 1'b1; end
                    6'h2b: d.alu_fun = 6'b110101;
                    6'h00: begin d.alu_fun = 6'b100000; d.src1_shamt = 1'b1; end
                    6'h02: begin d.alu_fun = 6'b100001; d.src1_shamt = 1'b1; end
                    6'h03: begin d.alu_fun = 6'b100011; d.src1_shamt = 1'b1; end
                    6'h08, 6'h09: d.alu_fun = 6'b011010;
                    default: d.illegal = 1'b1;
                endcase
            end
            6'h01: begin
                if (rt == 5'd0) begin
                    d.alu_fun = 6'b111011;
                    d.sign    = 1'b1;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            6'h02, 6'h03: d.alu_fun = 6'b000000;
            6'h04: begin d.alu_fun = 6'b110011; d.sign = 1'b1; end
            6'h05: begin d.alu_fun = 6'b110001; d.sign = 1'b1; end
            6'h06: begin d.alu_fun = 6'b111101; d.sign = 1'b1; end
            6'h07: begin d.alu_fun = 6'b111111; d.sign = 1'b1; end
            6'h08: begin d.sign = 1'b1; d.src2_imm = 1'b1; d.ext_signed = 1'b1; end
            6'h09: begin d.src2_imm = 1'b1; d.ext_signed = 1'b1; end
            6'h0a: begin
                d.alu_fun = 6'b110101; d.sign = 1'b1;
                d.src2_imm = 1'b1; d.ext_signed = 1'b1;
            end
            6'h0b: begin d.alu_fun = 6'b110101; d.src2_imm = 1'b1; d.ext_signed = 1'b1; end
            6'h0c: begin d.alu_fun = 6'b011000; d.src2_imm = 1'b1; end
            6'h0f: begin d.lui = 1'b1; d.src2_imm = 1'b1; end
            6'h23, 6'h2b: begin d.src2_imm = 1'b1; d.ext_signed = 1'b1; end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    logic        out_valid_r;
    dec_t        out_dec_r;
    logic [31:0] out_instr_r;
    logic [31:0] out_tag_r;
    logic        skid_valid_r;
    logic [31:0] skid_instr_r;
    logic [31:0] skid_tag_r;
    logic        in_ready_r;

    logic        accept_s;
    logic        consume_s;
    logic        trap_enter_s;
    logic        trap_next_s;
    logic        out_load_s;
    logic        out_sel_skid_s;
    logic        out_clear_s;
    logic        skid_load_s;
    logic        skid_clear_s;
    logic        skid_valid_next_s;
    logic [31:0] load_instr_s;
    logic [31:0] load_tag_s;

    // flush outranks both handshakes
    assign accept_s  = in_valid & in_ready_r & ~flush;
    assign consume_s = out_valid_r & out_ready & ~flush;

`ifdef DECODE_ILLEGAL_TRAP_EN
    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;
    state_t state_r;
    state_t state_next_s;

    assign trap_enter_s = consume_s & out_dec_r.illegal & (state_r == RUN);
    assign trap_next_s  = (state_next_s == TRAP);
    assign illegal      = out_dec_r.illegal;

    // Trap state register; only reset or exc_ack leave TRAP
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Trap next-state: enter when an illegal entry is consumed
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN:     if (trap_enter_s) state_next_s = TRAP; else state_next_s = RUN;
            TRAP:    if (exc_ack) state_next_s = RUN; else state_next_s = TRAP;
            default: state_next_s = RUN;
        endcase
    end
`else
    logic [1:0] unused_trap_s;
    assign unused_trap_s = {exc_ack, out_dec_r.illegal};
    assign trap_enter_s  = 1'b0;
    assign trap_next_s   = 1'b0;
    assign illegal       = 1'b0;
`endif

    // Routing of OUT/SKID loads; a trap entry discards whatever sits in SKID
    always_comb begin
        out_load_s     = 1'b0;
        out_sel_skid_s = 1'b0;
        out_clear_s    = 1'b0;
        skid_load_s    = 1'b0;
        skid_clear_s   = 1'b0;
        if (flush) begin
            out_clear_s  = 1'b1;
            skid_clear_s = 1'b1;
        end else if (consume_s) begin
            if (skid_valid_r && !trap_enter_s) begin
                out_load_s     = 1'b1;
                out_sel_skid_s = 1'b1;
                if (accept_s) skid_load_s = 1'b1; else skid_clear_s = 1'b1;
            end else if (accept_s) begin
                out_load_s   = 1'b1;
                skid_clear_s = 1'b1;
            end else begin
                out_clear_s  = 1'b1;
                skid_clear_s = 1'b1;
            end
        end else if (!out_valid_r) begin
            if (accept_s) out_load_s = 1'b1; else out_clear_s = 1'b1;
        end else if (accept_s) begin
            skid_load_s = 1'b1;
        end else begin
            skid_load_s = 1'b0;
        end
    end

    // Source selection for OUT and the next SKID occupancy
    always_comb begin
        if (out_sel_skid_s) begin
            load_instr_s = skid_instr_r;
            load_tag_s   = skid_tag_r;
        end else begin
            load_instr_s = instr_in;
            load_tag_s   = tag_in;
        end
        if (skid_load_s) begin
            skid_valid_next_s = 1'b1;
        end else if (skid_clear_s) begin
            skid_valid_next_s = 1'b0;
        end else begin
            skid_valid_next_s = skid_valid_r;
        end
    end

    // OUT and SKID registers plus the registered ready flag
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_dec_r    <= '0;
            out_instr_r  <= 32'h0000_0000;
            out_tag_r    <= RESET_PC_TAG;
            skid_valid_r <= 1'b0;
            skid_instr_r <= 32'h0000_0000;
            skid_tag_r   <= 32'h0000_0000;
            in_ready_r   <= 1'b0;
        end else begin
            if (out_load_s) begin
                out_valid_r <= 1'b1;
                out_dec_r   <= decode(load_instr_s[31:26], load_instr_s[20:16], load_instr_s[5:0]);
                out_instr_r <= load_instr_s;
                out_tag_r   <= load_tag_s;
            end else if (out_clear_s) begin
                out_valid_r <= 1'b0;
                out_dec_r   <= '0;
                out_instr_r <= 32'h0000_0000;
                out_tag_r   <= RESET_PC_TAG;
            end
            if (skid_load_s) begin
                skid_valid_r <= 1'b1;
                skid_instr_r <= instr_in;
                skid_tag_r   <= tag_in;
            end else if (skid_clear_s) begin
                skid_valid_r <= 1'b0;
            end
            in_ready_r <= ~skid_valid_next_s & ~trap_next_s;
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = out_valid_r;
    assign ALUFun         = out_dec_r.alu_fun;
    assign Sign           = out_dec_r.sign;
    assign alu_src1_shamt = out_dec_r.src1_shamt;
    assign alu_src2_imm   = out_dec_r.src2_imm;
    assign ext_signed     = out_dec_r.ext_signed;
    assign lui            = out_dec_r.lui;
    assign instr_out      = out_instr_r;
    assign tag_out        = out_tag_r;

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb_alu_op_decoder: directed plus randomized bench for alu_op_decoder.
// The reference keeps accepted instructions in a queue (at most two live)
// and decodes them from lookup tables filled from the opcode/funct lists.
// Macro DECODE_ILLEGAL_TRAP_EN enables the trap expectations.
module tb_alu_op_decoder;

    localparam logic [31:0] RST_TAG = 32'hBFC0_0000;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready, exc_ack;
    logic        in_ready, out_valid, Sign, alu_src1_shamt, alu_src2_imm;
    logic        ext_signed, lui, illegal;
    logic [5:0]  ALUFun;
    logic [31:0] instr_in, tag_in, instr_out, tag_out;

    alu_op_decoder #(.RESET_PC_TAG(RST_TAG)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .instr_in(instr_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .ALUFun(ALUFun),
        .Sign(Sign), .alu_src1_shamt(alu_src1_shamt), .alu_src2_imm(alu_src2_imm),
        .ext_signed(ext_signed), .lui(lui), .instr_out(instr_out),
        .tag_out(tag_out), .illegal(illegal), .exc_ack(exc_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] fun;
        logic sign, shamt, imm, ext, lu, ill;
    } exp_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] tag;
    } ent_t;

    exp_t r_tab [64];
    bit   r_ok  [64];
    exp_t i_tab [64];
    bit   i_ok  [64];

    ent_t q[$];
    bit   m_in_ready;
    bit   m_trap;
    bit   m_just_reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   tag_seq  = 0;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_r(input int fn, input logic [5:0] fun, input bit sg, input bit sh);
        r_tab[fn] = '{fun: fun, sign: sg, shamt: sh, imm: 1'b0, ext: 1'b0, lu: 1'b0, ill: 1'b0};
        r_ok[fn]  = 1'b1;
    endtask

    task automatic set_i(input int op, input logic [5:0] fun, input bit sg, input bit im,
                         input bit ex, input bit lu);
        i_tab[op] = '{fun: fun, sign: sg, shamt: 1'b0, imm: im, ext: ex, lu: lu, ill: 1'b0};
        i_ok[op]  = 1'b1;
    endtask

    task automatic init_tables();
        for (int k = 0; k < 64; k++) begin r_ok[k] = 1'b0; i_ok[k] = 1'b0; end
        set_r('h20, 6'b000000, 1, 0); set_r('h21, 6'b000000, 0, 0);
        set_r('h22, 6'b000001, 1, 0); set_r('h23, 6'b000001, 0, 0);
        set_r('h24, 6'b011000, 0, 0); set_r('h25, 6'b011110, 0, 0);
        set_r('h26, 6'b010110, 0, 0); set_r('h27, 6'b010001, 0, 0);
        set_r('h2a, 6'b110101, 1, 0); set_r('h2b, 6'b110101, 0, 0);
        set_r('h00, 6'b100000, 0, 1); set_r('h02, 6'b100001, 0, 1);
        set_r('h03, 6'b100011, 0, 1);
        set_r('h08, 6'b011010, 0, 0); set_r('h09, 6'b011010, 0, 0);
        set_i('h08, 6'b000000, 1, 1, 1, 0); set_i('h09, 6'b000000, 0, 1, 1, 0);
        set_i('h0a, 6'b110101, 1, 1, 1, 0); set_i('h0b, 6'b110101, 0, 1, 1, 0);
        set_i('h0c, 6'b011000, 0, 1, 0, 0); set_i('h0f, 6'b000000, 0, 1, 0, 1);
        set_i('h23, 6'b000000, 0, 1, 1, 0); set_i('h2b, 6'b000000, 0, 1, 1, 0);
        set_i('h04, 6'b110011, 1, 0, 0, 0); set_i('h05, 6'b110001, 1, 0, 0, 0);
        set_i('h06, 6'b111101, 1, 0, 0, 0); set_i('h07, 6'b111111, 1, 0, 0, 0);
        set_i('h02, 6'b000000, 0, 0, 0, 0); set_i('h03, 6'b000000, 0, 0, 0, 0);
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        e = '0;
        if (w[31:26] == 6'h00) begin
            if (r_ok[w[5:0]]) e = r_tab[w[5:0]]; else e.ill = 1'b1;
        end else if (w[31:26] == 6'h01) begin
            if (w[20:16] == 5'd0) begin e.fun = 6'b111011; e.sign = 1'b1; end
            else e.ill = 1'b1;
        end else if (i_ok[w[31:26]]) begin
            e = i_tab[w[31:26]];
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // One clock: drive inputs, advance the reference, compare after the edge
    task automatic cyc(input bit rst, input bit fl, input bit iv, input logic [31:0] ins,
                       input bit ordy, input bit ack);
        bit acc, con, tenter;
        exp_t e;
        tag_seq++;
        reset = rst; flush = fl; in_valid = iv; instr_in = ins;
        tag_in = 32'h0040_0000 + 32'(tag_seq) * 32'd4;
        out_ready = ordy; exc_ack = ack;
        acc    = !rst && !fl && iv && m_in_ready;
        con    = !rst && !fl && ordy && (q.size() > 0);
        tenter = 1'b0;
        @(posedge clk);
        if (rst) begin
            q.delete(); m_trap = 1'b0; m_in_ready = 1'b0; m_just_reset = 1'b1;
        end else begin
            m_just_reset = 1'b0;
            if (fl) begin
                q.delete();
            end else begin
                if (con) begin
                    tenter = TRAP_EN && !m_trap && ref_decode(q[0].instr).ill;
                    void'(q.pop_front());
                end
                if (tenter) q.delete();
                if (acc) q.push_back('{instr: ins, tag: tag_in});
            end
            if (m_trap && ack) m_trap = 1'b0;
            else if (tenter) m_trap = 1'b1;
            m_in_ready = (q.size() < 2) && !m_trap;
        end
        #1;
        check_eq("out_valid", out_valid, q.size() > 0);
        check_eq("in_ready", in_ready, m_in_ready);
        if (q.size() > 0) begin
            e = ref_decode(q[0].instr);
            check_eq("ALUFun", ALUFun, e.fun);
            check_eq("ctl{Sign,sh,imm,ext,lui}", {Sign, alu_src1_shamt, alu_src2_imm, ext_signed, lui},
                     {e.sign, e.shamt, e.imm, e.ext, e.lu});
            check_eq("illegal", illegal, TRAP_EN && e.ill);
            check_eq("instr_out", instr_out, q[0].instr);
            check_eq("tag_out", tag_out, q[0].tag);
        end else begin
            check_eq("tag_out_idle", tag_out, RST_TAG);
        end
        if (m_just_reset) begin
            check_eq("rst_dec", {ALUFun, Sign, alu_src1_shamt, alu_src2_imm, ext_signed, lui, illegal}, 0);
            check_eq("rst_instr", instr_out, 0);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  f;
        int k;
        w = $urandom();
        k = $urandom_range(0, 3);
        case (k)
            0: begin
                do f = 6'($urandom_range(0, 63)); while (!r_ok[f]);
                w[31:26] = 6'h00; w[5:0] = f;
            end
            1: begin
                do f = 6'($urandom_range(0, 63)); while (!i_ok[f]);
                w[31:26] = f;
            end
            2: begin
                w[31:26] = 6'h01;
                w[20:16] = ($urandom_range(0, 3) == 0) ? 5'd1 : 5'd0;
            end
            default: w = w;
        endcase
        return w;
    endfunction

    initial begin
        init_tables();
        m_in_ready = 1'b0; m_trap = 1'b0; m_just_reset = 1'b0;

        // reset and first ready cycle
        repeat (3) cyc(1, 0, 0, 32'h0, 0, 0);
        check_eq("rst_in_ready", in_ready, 1'b0);
        cyc(0, 0, 0, 32'h0, 1, 0);
        check_eq("post_rst_in_ready", in_ready, 1'b1);

        // add, then sll / sltiu back to back
        cyc(0, 0, 1, 32'h012A4020, 1, 0);
        check_eq("add_fun", ALUFun, 6'b000000);
        check_eq("add_sign", Sign, 1'b1);
        check_eq("add_imm", alu_src2_imm, 1'b0);
        check_eq("add_valid", out_valid, 1'b1);
        cyc(0, 0, 1, 32'h00094100, 1, 0);
        check_eq("sll_fun", ALUFun, 6'b100000);
        check_eq("sll_shamt_sel", alu_src1_shamt, 1'b1);
        check_eq("sll_shamt", instr_out[10:6], 5'd4);
        cyc(0, 0, 1, 32'h2D28FFFF, 1, 0);
        check_eq("sltiu_fun", ALUFun, 6'b110101);
        check_eq("sltiu_sign", Sign, 1'b0);
        check_eq("sltiu_ext", ext_signed, 1'b1);
        cyc(0, 0, 0, 32'h0, 1, 0);

        // back-pressure: beq then bne held, then released in order
        cyc(0, 0, 1, 32'h11090003, 0, 0);
        cyc(0, 0, 1, 32'h15090003, 0, 0);
        check_eq("bp_in_ready", in_ready, 1'b0);
        check_eq("bp_beq_fun", ALUFun, 6'b110011);
        cyc(0, 0, 1, 32'h012A4020, 0, 0);
        check_eq("bp_hold_fun", ALUFun, 6'b110011);
        cyc(0, 0, 0, 32'h0, 1, 0);
        check_eq("bp_bne_fun", ALUFun, 6'b110001);
        check_eq("bp_ready_back", in_ready, 1'b1);
        cyc(0, 0, 0, 32'h0, 1, 0);
        check_eq("bp_drained", out_valid, 1'b0);

        // flush with both entries full and a pending input
        cyc(0, 0, 1, 32'h012A4020, 0, 0);
        cyc(0, 0, 1, 32'h012A4024, 0, 0);
        cyc(0, 1, 1, 32'h012A4025, 0, 0);
        check_eq("flush_valid", out_valid, 1'b0);
        check_eq("flush_ready", in_ready, 1'b1);
        repeat (2) cyc(0, 0, 0, 32'h0, 1, 0);
        // flush with only OUT full and an acceptable input
        cyc(0, 0, 1, 32'h012A4026, 0, 0);
        cyc(0, 1, 1, 32'h012A4027, 1, 0);
        check_eq("flush1_valid", out_valid, 1'b0);
        repeat (2) cyc(0, 0, 0, 32'h0, 1, 0);

        // bltz and its rt=1 sibling
        cyc(0, 0, 1, 32'h05200002, 1, 0);
        check_eq("bltz_fun", ALUFun, 6'b111011);
        cyc(0, 0, 1, 32'h05210002, 1, 0);
        check_eq("rt1_illegal", illegal, TRAP_EN);
        check_eq("rt1_fun", ALUFun, 6'b000000);
        cyc(0, 0, 0, 32'h0, 1, 0);
        cyc(0, 0, 0, 32'h0, 1, 1);
        check_eq("after_ack_ready", in_ready, 1'b1);

`ifdef DECODE_ILLEGAL_TRAP_EN
        // trap entry, stall, exc_ack release, and reset mid-trap
        cyc(0, 0, 1, 32'hFC000000, 0, 0);
        check_eq("trap_illegal", illegal, 1'b1);
        cyc(0, 0, 0, 32'h0, 1, 0);
        check_eq("trap_ready0", in_ready, 1'b0);
        repeat (3) begin
            cyc(0, 1, 1, 32'h012A4020, 1, 0);
            check_eq("trap_stall", in_ready, 1'b0);
            check_eq("trap_noout", out_valid, 1'b0);
        end
        cyc(0, 0, 0, 32'h0, 1, 1);
        check_eq("trap_ack_ready", in_ready, 1'b1);
        cyc(0, 0, 1, 32'hFC000000, 1, 0);
        cyc(0, 0, 0, 32'h0, 1, 0);
        check_eq("trap2_ready0", in_ready, 1'b0);
        cyc(1, 0, 0, 32'h0, 1, 0);
        cyc(0, 0, 0, 32'h0, 1, 0);
        check_eq("trap_rst_ready", in_ready, 1'b1);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 9) < 7, rand_instr(),
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
